// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode datapath: widths, reset PC and
// immediate-format encodings.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

endpackage

// File: rtl/datapath1_if.sv
// Bus between datapath1 and its neighbours (instruction memory, control,
// datapath2). The slave side is datapath1 itself.
interface datapath1_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] Instr;
    logic [XLEN-1:0] Result;
    logic            RegWrite;
    logic [2:0]      ImmSrc;
    logic            PCSrc;
    logic            PCEn;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] WriteData;
    logic [XLEN-1:0] ImmExt;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;

    modport master (
        output Instr, Result, RegWrite, ImmSrc, PCSrc, PCEn,
        input  PC, PCPlus4, SrcA, WriteData, ImmExt, op, funct3, funct7b5
    );

    modport slave (
        input  Instr, Result, RegWrite, ImmSrc, PCSrc, PCEn,
        output PC, PCPlus4, SrcA, WriteData, ImmExt, op, funct3, funct7b5
    );

endinterface

// File: rtl/extend.sv
// Combinational immediate extension; every format sign-extends from bit 31.
module extend
    import riscv_pkg::*;
(
    input  logic [31:7]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm_ext
);

    // Select and sign-extend the immediate field for the requested format.
    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm_ext = {instr[31:12], 12'b0};
            default: imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/mux2x1_32bits.sv
// Generic 32-bit two-input multiplexer.
module mux2x1_32bits (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic        s,
    output logic [31:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, x0 hard-wired to zero. No write-to-read bypass.
module regfile
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    // Next register state: apply the write unless it targets x0.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Register storage; reset clears every entry and wins over a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/datapath1.sv
// Fetch/decode half of the single-cycle core: PC register with branch/jump
// selection, register file, immediate extension and decode slices.
module datapath1
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    datapath1_if.slave bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] imm_ext;

    // Both adders wrap modulo 2^32.
    assign pc_plus4  = pc_q + 32'd4;
    assign pc_target = pc_q + imm_ext;

    mux2x1_32bits u_pc_mux (
        .d0 (pc_plus4),
        .d1 (pc_target),
        .s  (bus.PCSrc),
        .y  (pc_next)
    );

    // PC advances only when enabled; otherwise it holds for a stall/halt.
    always_comb begin
        pc_d = pc_q;
        if (bus.PCEn) begin
            pc_d = pc_next;
        end
    end

    // PC register with asynchronous return to the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.RegWrite),
        .waddr  (bus.Instr[11:7]),
        .wdata  (bus.Result),
        .raddr1 (bus.Instr[19:15]),
        .raddr2 (bus.Instr[24:20]),
        .rdata1 (bus.SrcA),
        .rdata2 (bus.WriteData)
    );

    extend u_extend (
        .instr   (bus.Instr[31:7]),
        .imm_src (bus.ImmSrc),
        .imm_ext (imm_ext)
    );

    assign bus.PC       = pc_q;
    assign bus.PCPlus4  = pc_plus4;
    assign bus.ImmExt   = imm_ext;
    assign bus.op       = bus.Instr[6:0];
    assign bus.funct3   = bus.Instr[14:12];
    assign bus.funct7b5 = bus.Instr[30];

endmodule

// File: tb/tb_datapath1.sv
// Self-checking bench for datapath1: directed scenarios plus randomized
// cycles compared against a behavioural model of PC and register state.
module tb_datapath1;

    logic clk;
    logic rst_n;

    datapath1_if bus ();

    datapath1 #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_regs [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_imm(input logic [31:0] i, input logic [2:0] s);
        int v;
        v = 0;
        case (s)
            3'd0: begin v = int'(i[31:20]); if (i[31]) v -= 4096; end
            3'd1: begin v = int'({i[31:25], i[11:7]}); if (i[31]) v -= 4096; end
            3'd2: begin v = int'({i[31], i[7], i[30:25], i[11:8], 1'b0}); if (i[31]) v -= 8192; end
            3'd3: begin v = int'({i[31], i[19:12], i[20], i[30:21], 1'b0}); if (i[31]) v -= 2097152; end
            3'd4: v = int'(i & 32'hFFFF_F000);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    endtask

    // Apply inputs just after a rising edge, then compare all outputs at the falling edge.
    task automatic settle(input logic [31:0] ins, input logic [31:0] res, input logic rw,
                          input logic [2:0] is, input logic ps, input logic pe);
        bus.Instr    = ins;
        bus.Result   = res;
        bus.RegWrite = rw;
        bus.ImmSrc   = is;
        bus.PCSrc    = ps;
        bus.PCEn     = pe;
        @(negedge clk);
        chk("pc",        bus.PC,        m_pc);
        chk("pcplus4",   bus.PCPlus4,   m_pc + 32'd4);
        chk("srca",      bus.SrcA,      m_regs[ins[19:15]]);
        chk("writedata", bus.WriteData, m_regs[ins[24:20]]);
        chk("immext",    bus.ImmExt,    model_imm(ins, is));
        chk("op",        32'(bus.op),       32'(ins & 32'h7F));
        chk("funct3",    32'(bus.funct3),   32'((ins >> 12) & 32'h7));
        chk("funct7b5",  32'(bus.funct7b5), 32'((ins >> 30) & 32'h1));
    endtask

    // Take the rising edge and advance the model with the inputs that were applied.
    task automatic advance();
        logic [4:0] rd;
        @(posedge clk);
        rd = bus.Instr[11:7];
        if (bus.RegWrite && rd != 5'd0) m_regs[rd] = bus.Result;
        if (bus.PCEn) m_pc = bus.PCSrc ? m_pc + model_imm(bus.Instr, bus.ImmSrc) : m_pc + 32'd4;
        #1;
    endtask

    // Jump to an absolute PC using an I-format offset (target must be within +/-2 KiB).
    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] d;
        d = target - m_pc;
        settle({d[11:0], 20'h00013}, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);
        advance();
        chk("goto_pc", bus.PC, target);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.Instr    = 32'h0;
        bus.Result   = 32'h0;
        bus.RegWrite = 1'b0;
        bus.ImmSrc   = 3'd0;
        bus.PCSrc    = 1'b0;
        bus.PCEn     = 1'b0;
        model_reset();
        #2;
        chk("rst_pc",      bus.PC,      32'h0);
        chk("rst_pcplus4", bus.PCPlus4, 32'h4);
        for (int i = 0; i < 32; i++) begin
            bus.Instr = {7'd0, i[4:0], i[4:0], 3'd0, 5'd0, 7'h33};
            #1;
            chk("rst_srca", bus.SrcA,      32'h0);
            chk("rst_wd",   bus.WriteData, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Writeback then read back through rs1.
        settle(32'h00500093, 32'd5, 1'b1, 3'd0, 1'b0, 1'b1);
        advance();
        settle(32'h00008093, 32'd9, 1'b1, 3'd0, 1'b0, 1'b1);
        chk("same_cycle_old", bus.SrcA, 32'd5);
        advance();
        settle(32'h00008013, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("after_write", bus.SrcA, 32'd9);
        advance();

        // x0 protection.
        settle(32'h00000013, 32'hDEAD_BEEF, 1'b1, 3'd0, 1'b0, 1'b1);
        advance();
        settle(32'h00000013, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("x0_read", bus.SrcA, 32'h0);
        advance();

        // Immediate formats.
        settle(32'hFFF0_0093, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("imm_i_neg1", bus.ImmExt, 32'hFFFF_FFFF);
        advance();
        settle(32'hFE00_0EE3, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0);
        chk("imm_b_neg4", bus.ImmExt, 32'hFFFF_FFFC);
        advance();
        settle(32'h1234_52B7, 32'h0, 1'b0, 3'd4, 1'b0, 1'b0);
        chk("imm_u", bus.ImmExt, 32'h1234_5000);
        advance();

        // Branch, jump, fall-through from 0x20.
        goto_pc(32'h20);
        settle(32'hFE00_0EE3, 32'h0, 1'b0, 3'd2, 1'b1, 1'b1);
        advance();
        chk("branch_back", bus.PC, 32'h1C);
        goto_pc(32'h20);
        settle(32'h0080_006F, 32'h0, 1'b0, 3'd3, 1'b1, 1'b1);
        advance();
        chk("jump_fwd", bus.PC, 32'h28);
        goto_pc(32'h20);
        settle(32'hFE00_0EE3, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1);
        advance();
        chk("fallthrough", bus.PC, 32'h24);

        // Stall holds the PC.
        goto_pc(32'h10);
        for (int k = 0; k < 3; k++) begin
            settle(32'h00000013, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
            advance();
            chk("stall_pc", bus.PC, 32'h10);
        end

        // Wrap past the top of the address space.
        goto_pc(32'hFFFF_FFFC);
        settle(32'h00000013, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        advance();
        chk("wrap_pc", bus.PC, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            settle($urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            advance();
        end

        // Asynchronous reset mid-run at PC = 0x40.
        model_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        settle(32'h00000293, 32'h1234, 1'b1, 3'd0, 1'b0, 1'b1);
        advance();
        goto_pc(32'h40);
        settle(32'h00028013, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("pre_rst_pc",   bus.PC,   32'h40);
        chk("pre_rst_srca", bus.SrcA, 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc",      bus.PC,      32'h0);
        chk("async_rst_pcplus4", bus.PCPlus4, 32'h4);
        chk("async_rst_srca",    bus.SrcA,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("post_rst_hold", bus.PC, 32'h0);
        settle(32'h00028013, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        advance();
        chk("post_rst_step", bus.PC, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
